// File: rtl/operand_issue_stage.sv
// Registered operand-select stage: decodes the opcode and steers rs1, rs2 or
// the immediate onto the two ALU operand buses. The valid/ready handshake on
// each side is decoupled by an output register plus one skid entry. Illegal
// opcodes are flagged with the entry and tallied in a saturating counter.
module operand_issue_stage #(
  parameter int N    = 16,
  parameter int OPW  = 4,
  parameter int IMMW = 8,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  opcode,
  input  logic [N-1:0]    rs1_in,
  input  logic [N-1:0]    rs2_in,
  input  logic [IMMW-1:0] imm_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    op_a,
  output logic [N-1:0]    op_b,
  output logic [OPW-1:0]  opcode_out,
  output logic            illegal,
  output logic [CNTW-1:0] illegal_cnt
);

  typedef struct packed {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [OPW-1:0] op;
    logic           ill;
  } ent_t;

  localparam logic [OPW-1:0] OP_RR_MAX = OPW'(4);
  localparam logic [OPW-1:0] OP_RI_MAX = OPW'(7);
  localparam logic [OPW-1:0] OP_LI     = OPW'(8);

  ent_t dec, out_q, skid_q;
  logic out_vld, skid_vld;
  logic in_xfer, out_xfer;

  // Ready depends only on registered skid occupancy, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = !skid_vld;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_vld & out_ready;

  assign out_valid  = out_vld;
  assign op_a       = out_q.a;
  assign op_b       = out_q.b;
  assign opcode_out = out_q.op;
  assign illegal    = out_q.ill;

  // Opcode decode into an operand entry; codes above 0x8 (any width) are illegal.
  always_comb begin
    dec    = '0;
    dec.op = opcode;
    if (opcode <= OP_RR_MAX) begin
      dec.a = rs1_in;
      dec.b = rs2_in;
    end else if (opcode <= OP_RI_MAX) begin
      dec.a = rs1_in;
      dec.b = N'($signed(imm_in));
    end else if (opcode == OP_LI) begin
      dec.b = N'(imm_in);
    end else begin
      dec.ill = 1'b1;
    end
  end

  // Output register + skid entry. With skid valid, in_ready is low so no new
  // entry can arrive; the skid simply drains into the output on a transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_q    <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
    end else if (skid_vld) begin
      if (out_xfer) begin
        out_q    <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (!out_vld || out_xfer) begin
      out_vld <= in_xfer;
      if (in_xfer) out_q <= dec;
    end else if (in_xfer) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end

  // Saturating count of accepted illegal opcodes; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_cnt <= '0;
    else if (in_xfer && dec.ill && (illegal_cnt != {CNTW{1'b1}}))
      illegal_cnt <= illegal_cnt + 1'b1;
  end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed and randomized bench for operand_issue_stage. The counter is built
// narrow (CNTW=2) so saturation is reached quickly.
module tb_operand_issue_stage;
  localparam int N = 16, OPW = 4, IMMW = 8, CNTW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [OPW-1:0]  opcode;
  logic [N-1:0]    rs1_in, rs2_in;
  logic [IMMW-1:0] imm_in;
  logic            out_valid, out_ready;
  logic [N-1:0]    op_a, op_b;
  logic [OPW-1:0]  opcode_out;
  logic            illegal;
  logic [CNTW-1:0] illegal_cnt;

  operand_issue_stage #(.N(N), .OPW(OPW), .IMMW(IMMW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .opcode_out(opcode_out),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [OPW-1:0] op;
    logic           ill;
  } exp_t;

  int errs = 0, chks = 0;
  exp_t q[$];
  int unsigned cnt_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] r1,
                       input logic [15:0] r2, input logic [7:0] im);
    in_valid = v; opcode = op; rs1_in = r1; rs2_in = r2; imm_in = im;
  endtask

  // Independent reference decode.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] r1,
                                 input logic [15:0] r2, input logic [7:0] im);
    exp_t e;
    e.op = op; e.ill = 1'b0; e.a = '0; e.b = '0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin e.a = r1; e.b = r2; end
      4'h5, 4'h6, 4'h7: begin e.a = r1; e.b = {{8{im[7]}}, im}; end
      4'h8: e.b = {8'h00, im};
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  initial begin
    int pushed, cyc;
    exp_t e;
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b1, 4'hC, 16'h1111, 16'h2222, 8'h33);   // handshake during reset is ignored
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);

    // Reg-reg
    rst_n = 1'b1; out_ready = 1'b1;
    drive(1'b1, 4'h2, 16'h1234, 16'h00FF, 8'h00);
    step();
    drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0);
    chk("rr_valid", out_valid, 1);
    chk("rr_a", op_a, 16'h1234);
    chk("rr_b", op_b, 16'h00FF);
    chk("rr_opc", opcode_out, 4'h2);
    chk("rr_ill", illegal, 0);
    step();
    chk("rr_drain", out_valid, 0);

    // Reg-imm sign-extend, then load-imm zero-extend, back to back
    drive(1'b1, 4'h6, 16'h0010, 16'hBEEF, 8'h80);
    step();
    chk("ri_a", op_a, 16'h0010);
    chk("ri_b", op_b, 16'hFF80);
    drive(1'b1, 4'h8, 16'h5555, 16'hBEEF, 8'h80);
    step();
    chk("li_a", op_a, 16'h0000);
    chk("li_b", op_b, 16'h0080);
    chk("li_opc", opcode_out, 4'h8);

    // Illegal opcode, then saturation
    drive(1'b1, 4'hC, 16'hAAAA, 16'h1234, 8'h7F);
    step();
    chk("il_a", op_a, 0);
    chk("il_b", op_b, 0);
    chk("il_flag", illegal, 1);
    chk("il_cnt1", illegal_cnt, 1);
    drive(1'b1, 4'hF, 16'h0, 16'h0, 8'h0);
    step();
    chk("il_cnt2", illegal_cnt, 2);
    for (int i = 0; i < 4; i++) step();
    chk("il_cnt_sat", illegal_cnt, 3);
    drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0);
    step();
    chk("il_drain", out_valid, 0);

    // Backpressure: A held, B in skid, C stalled, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'h000A, 16'h0A0A, 8'h0);
    step();
    chk("bp_a_out", op_a, 16'h000A);
    drive(1'b1, 4'h1, 16'h000B, 16'h0B0B, 8'h0);
    step();
    chk("bp_in_ready_low", in_ready, 0);
    drive(1'b1, 4'h3, 16'h000C, 16'h0C0C, 8'h0);
    step();
    chk("bp_hold_a", op_a, 16'h000A);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_c_stalled", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_b_out", op_a, 16'h000B);
    chk("bp_b_opc", opcode_out, 4'h1);
    step();
    drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0);
    chk("bp_c_out", op_a, 16'h000C);
    chk("bp_c_b", op_b, 16'h0C0C);
    step();
    chk("bp_drain", out_valid, 0);

    // Reset mid-stall with both entries held
    out_ready = 1'b0;
    drive(1'b1, 4'h0, 16'h0001, 16'h0001, 8'h0);
    step(); step();
    chk("ms_full", in_ready, 0);
    rst_n = 1'b0;
    drive(1'b1, 4'hD, 16'h0, 16'h0, 8'h0);
    step();
    chk("ms_valid", out_valid, 0);
    chk("ms_ready", in_ready, 1);
    chk("ms_cnt", illegal_cnt, 0);
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 16'h0, 16'h0, 8'h0);
    step();
    chk("ms_after", out_valid, 0);

    // Randomized stream vs scoreboard
    cnt_m = 0; pushed = 0; cyc = 0;
    while ((pushed < 1000 || q.size() != 0) && cyc < 20000) begin
      chk("rnd_in_ready", in_ready, (q.size() < 2));
      chk("rnd_out_valid", out_valid, (q.size() > 0));
      chk("rnd_cnt", illegal_cnt, cnt_m);
      if (q.size() > 0) begin
        chk("rnd_a", op_a, q[0].a);
        chk("rnd_b", op_b, q[0].b);
        chk("rnd_opc", opcode_out, q[0].op);
        chk("rnd_ill", illegal, q[0].ill);
      end
      out_ready = 1'($urandom_range(0, 3) != 0);
      drive((pushed < 1000) && ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            16'($urandom), 16'($urandom), 8'($urandom));
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = model(opcode, rs1_in, rs2_in, imm_in);
        q.push_back(e);
        if (e.ill && cnt_m < 3) cnt_m++;
        pushed++;
      end
      step();
      cyc++;
    end
    chk("rnd_done_in_budget", (cyc < 20000), 1);
    chk("rnd_final_cnt", illegal_cnt, cnt_m);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Registered operand-select stage between the register file read and the ALU; a parametrised successor to the combinational rs1 operand mux.
- Decodes opcode to steer rs1, rs2 or immediate onto two ALU operand buses.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer for full throughput under backpressure.
- Flags illegal opcodes and counts them in a saturating counter.

Parameters:
- N, 16, operand data width.
- OPW, 4, opcode width (>=4).
- IMMW, 8, immediate width (IMMW <= N).
- CNTW, 8, illegal-opcode counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- opcode  in  OPW  instruction opcode.
- rs1_in  in  N  register source 1 value.
- rs2_in  in  N  register source 2 value.
- imm_in  in  IMMW  instruction immediate.
- out_valid  out  1  operands valid downstream.
- out_ready  in  1  ALU accepts operands.
- op_a  out  N  ALU operand A.
- op_b  out  N  ALU operand B.
- opcode_out  out  OPW  opcode accompanying operands.
- illegal  out  1  current output entry had an illegal opcode.
- illegal_cnt  out  CNTW  saturating count of illegal opcodes accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0; op_a, op_b, opcode_out=0; illegal=0; illegal_cnt=0; skid entry invalidated.
  - Any handshake during a reset cycle is ignored.
  - Reset mid-transfer drops both held entries; no partial state survives.
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !skid_valid (registered state, no combinational path from out_ready).
- Decode (applied on input transfer):
  - 0x0-0x4 (reg-reg ALU): op_a=rs1_in, op_b=rs2_in.
  - 0x5-0x7 (reg-imm): op_a=rs1_in, op_b=sign-extend(imm_in) to N.
  - 0x8 (load-imm): op_a=0, op_b=zero-extend(imm_in).
  - All other codes: op_a=0, op_b=0, illegal=1.
  - opcode_out always carries the accepted opcode unchanged.
- Latency: an accepted instruction appears on outputs the next cycle when the output register is free or drained that cycle.
- Skid buffer, per cycle:
  - Output empty, or output transferring with skid empty: accepted entry loads the output register.
  - Output full, not transferring, and input accepted: entry goes to skid; in_ready drops next cycle.
  - Output transferring with skid valid: skid moves to output. A new input cannot arrive that cycle because in_ready=0.
  - No transfer: outputs hold stable; out_valid never drops without a transfer.
- Throughput: 1 instruction/cycle while out_ready=1; no bubbles.
- Ordering: strictly FIFO; no entry dropped or duplicated.
- illegal_cnt:
  - Increments by 1 on each input transfer with an illegal opcode.
  - Saturates at 2^CNTW-1 and does not wrap.
  - Cleared only by reset.
- Simultaneous input and output transfer: both complete in the same cycle.
- Opcode values above 0xF when OPW>4 are illegal.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, illegal_cnt=0; op_a/op_b=0.
- opcode=0x2, rs1=0x1234, rs2=0x00FF, out_ready=1 -> next cycle out_valid=1, op_a=0x1234, op_b=0x00FF, opcode_out=0x2, illegal=0.
- opcode=0x6, rs1=0x0010, imm=0x80 -> op_b=0xFF80; opcode=0x8, imm=0x80 -> op_a=0, op_b=0x0080.
- opcode=0xC, rs1=0xAAAA -> op_a=0, op_b=0, illegal=1, illegal_cnt=1. With CNTW=2, drive 5 illegal ops -> illegal_cnt saturates at 3.
- Backpressure: stream A, B, C with out_ready=0 -> A held on outputs, B in skid, in_ready=0, C stalled. Raise out_ready -> A, B, C emerge in order on consecutive cycles with no loss.
- Random in_valid/out_ready over 1000 instructions vs scoreboard -> in-order, exact match. Reset mid-stall -> out_valid=0, in_ready=1 next cycle.
